// File: rtl/mod_n_counter_sched.sv
// Shared mod-n interval counter with two round-robin requesters.
// Winner gets m*r counting cycles, then a one-cycle done pulse.
module mod_n_counter_sched #(
  parameter int N = 4,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] mod0,
  input  logic [C-1:0] rep0,
  input  logic         req1,
  input  logic [N-1:0] mod1,
  input  logic [C-1:0] rep1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         busy,
  output logic         tc,
  output logic [N-1:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_q, last_d;
  logic [N:0]   m_q, m_d;
  logic [C:0]   r_q, r_d;
  logic [C:0]   pc_q, pc_d;
  logic [N-1:0] out_q, out_d;
  logic         gnt0_q, gnt0_d;
  logic         gnt1_q, gnt1_d;
  logic         done0_q, done0_d;
  logic         done1_q, done1_d;

  logic         req_any;
  logic         win;
  logic         own_req;
  logic [N-1:0] mod_w;
  logic [C-1:0] rep_w;
  logic [N:0]   mm1;
  logic [C:0]   rm1;
  logic         term;
  logic         last_pc;

  assign req_any = req0 | req1;
  // On a tie the requester not granted last wins
  assign win     = (req0 & req1) ? ~last_q : req1;
  assign own_req = owner_q ? req1 : req0;
  assign mod_w   = win ? mod1 : mod0;
  assign rep_w   = win ? rep1 : rep0;
  assign mm1     = m_q - (N+1)'(1);
  assign rm1     = r_q - (C+1)'(1);
  assign term    = (out_q == mm1[N-1:0]);
  assign last_pc = (pc_q == rm1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      m_q     <= '0;
      r_q     <= '0;
      pc_q    <= '0;
      out_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      m_q     <= m_d;
      r_q     <= r_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_any) state_d = RUN;
      RUN: begin
        if (!own_req) state_d = IDLE;
        else if (term && last_pc) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    m_d     = m_q;
    r_d     = r_q;
    pc_d    = pc_q;
    out_d   = out_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        out_d = '0;
        if (req_any) begin
          owner_d = win;
          last_d  = win;
          m_d     = (mod_w == '0) ? {1'b1, {N{1'b0}}}
                                  : {1'b0, mod_w};
          r_d     = (rep_w == '0) ? (C+1)'(1)
                                  : {1'b0, rep_w};
          pc_d    = '0;
          gnt0_d  = ~win;
          gnt1_d  = win;
        end
      end
      RUN: begin
        if (!own_req) begin
          out_d  = '0;
          gnt0_d = 1'b0;
          gnt1_d = 1'b0;
        end else if (term) begin
          out_d = '0;
          pc_d  = pc_q + (C+1)'(1);
          if (last_pc) begin
            done0_d = ~owner_q;
            done1_d = owner_q;
          end
        end else begin
          out_d = out_q + N'(1);
        end
      end
      DONE: begin
        out_d  = '0;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
      end
      default: begin
        out_d  = '0;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
      end
    endcase
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign out   = out_q;
  assign busy  = (state_q != IDLE);
  assign tc    = (state_q == RUN) && term;

endmodule

// File: tb/tb_mod_n_counter_sched.sv
// Directed bench for mod_n_counter_sched (N=4, C=4).
// Cycle c = sample taken 1ns after the c-th edge following stimulus.
module tb_mod_n_counter_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] mod0, mod1;
  logic [3:0] rep0, rep1;
  logic       gnt0, gnt1, done0, done1, busy, tc;
  logic [3:0] out;
  logic [9:0] obs;
  logic [9:0] exp_v;
  int         errors = 0;
  int         checks = 0;

  mod_n_counter_sched #(.N(4), .C(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .mod0(mod0), .rep0(rep0),
    .req1(req1), .mod1(mod1), .rep1(rep1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .busy(busy), .tc(tc), .out(out)
  );

  always #5 clk = ~clk;

  assign obs = {gnt0, gnt1, done0, done1, busy, tc, out};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {gnt0,gnt1,done0,done1,busy,tc,out} for one owner run
  function automatic logic [9:0] run_exp(input int c, input bit who,
                                         input int m, input int r);
    logic [9:0] e;
    int len;
    len = m * r;
    e = '0;
    if (c < len) begin
      e[9] = ~who;
      e[8] = who;
      e[5] = 1'b1;
      e[3:0] = 4'(c % m);
      e[4] = ((c % m) == m - 1);
    end else if (c == len) begin
      e[9] = ~who;
      e[8] = who;
      e[7] = ~who;
      e[6] = who;
      e[5] = 1'b1;
    end
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    req0 = 0; req1 = 0;
    mod0 = 0; mod1 = 0; rep0 = 0; rep1 = 0;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", obs, 10'b0);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=%b", obs, 10'b0);
    end
  endtask

  task automatic test_single;
    mod0 = 4'd10; rep0 = 4'd1; req0 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      exp_v = run_exp(c, 1'b0, 10, 1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single c=%0d got=%b exp=%b", c, obs, exp_v);
      end
      if (c == 3) begin
        mod0 = 4'd2;
        rep0 = 4'd5;
      end
      if (c == 10) req0 = 1'b0;
    end
  endtask

  task automatic test_tie;
    int st[4]  = '{0, 8, 15, 23};
    int ln[4]  = '{6, 5, 6, 5};
    int mm[4]  = '{3, 5, 3, 5};
    bit ow[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    #1;
    rst = 1'b0;
    mod0 = 4'd3; rep0 = 4'd2;
    mod1 = 4'd5; rep1 = 4'd1;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick;
      exp_v = '0;
      for (int k = 0; k < 4; k++)
        if (c >= st[k] && c <= st[k] + ln[k])
          exp_v = run_exp(c - st[k], ow[k], mm[k], ln[k] / mm[k]);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tie c=%0d got=%b exp=%b", c, obs, exp_v);
      end
      if (c == 28) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
  endtask

  task automatic test_mod_bounds;
    logic [3:0] mv[3] = '{4'd0, 4'd1, 4'd2};
    logic [3:0] rv[3] = '{4'd1, 4'd3, 4'd0};
    int em[3] = '{16, 1, 2};
    int er[3] = '{1, 3, 1};
    for (int k = 0; k < 3; k++) begin
      mod0 = mv[k]; rep0 = rv[k]; req0 = 1'b1;
      for (int c = 0; c <= em[k] * er[k] + 1; c++) begin
        tick;
        exp_v = run_exp(c, 1'b0, em[k], er[k]);
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL bounds k=%0d c=%0d got=%b exp=%b",
                   k, c, obs, exp_v);
        end
        if (c == em[k] * er[k]) req0 = 1'b0;
      end
    end
  endtask

  task automatic test_abandon;
    mod0 = 4'd10; rep0 = 4'd4; req0 = 1'b1;
    mod1 = 4'd3;  rep1 = 4'd1; req1 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick;
      exp_v = run_exp(c, 1'b0, 10, 4);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abandon c=%0d got=%b exp=%b", c, obs, exp_v);
      end
      if (c == 0) req1 = 1'b1;
      if (c == 15) req0 = 1'b0;
    end
    tick;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL abandon_idle got=%b exp=%b", obs, 10'b0);
    end
    for (int c = 0; c < 2; c++) begin
      tick;
      exp_v = run_exp(c, 1'b1, 3, 1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abandon_next c=%0d got=%b exp=%b",
                 c, obs, exp_v);
      end
    end
    req1 = 1'b0;
    tick;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL abandon_drop1 got=%b exp=%b", obs, 10'b0);
    end
  endtask

  task automatic test_reset_mid;
    mod1 = 4'd8; rep1 = 4'd2; req1 = 1'b1; req0 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick;
      exp_v = run_exp(c, 1'b1, 8, 2);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rstmid c=%0d got=%b exp=%b", c, obs, exp_v);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL rstmid_async got=%b exp=%b", obs, 10'b0);
    end
    tick;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL rstmid_hold got=%b exp=%b", obs, 10'b0);
    end
    rst = 1'b0;
    mod0 = 4'd2; rep0 = 4'd1; req0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      exp_v = run_exp(c, 1'b0, 2, 1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rstmid_tie c=%0d got=%b exp=%b", c, obs, exp_v);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL rstmid_end got=%b exp=%b", obs, 10'b0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_mod_bounds;
    test_abandon;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
